spi_ram_loader: RTL and testbench
=================================

// Module: spi_ram_loader
// PURPOSE
//  SPI slave (mode 0) bridge that lets an external host load and read back the program/data RAM over SPI.
//  Sits directly upstream of single_port_ram and drives the RAM's master-side port (en/we/addr/wdata, rdata).
//  Holds the CPU off via busy while a frame is in progress.
//  Supports burst write (0x02) and burst read (0x03) with address auto-increment.
// PARAMETERS
//  ADDR_WIDTH  8   RAM word-address width; also the length in bits of the SPI address phase
//  DATA_WIDTH  32  RAM word width; also the length in bits of each SPI data word
//  CMD_WRITE   8'h02  write-burst command code
//  CMD_READ    8'h03  read-burst command code
// PORTS
//  clk         in   1           system clock; must run at >= 8x sclk
//  rst         in   1           asynchronous reset, active-high
//  spi_sclk    in   1           SPI clock from host (asynchronous to clk)
//  spi_cs_n    in   1           SPI chip select, active-low
//  spi_mosi    in   1           host -> block serial data, MSB first
//  spi_miso    out  1           block -> host serial data, MSB first
//  mem_en      out  1           RAM access strobe, 1-cycle pulse per word
//  mem_we      out  1           RAM write enable, only ever asserted together with mem_en
//  mem_addr    out  ADDR_WIDTH  RAM word address
//  mem_wdata   out  DATA_WIDTH  RAM write data
//  mem_rdata   in   DATA_WIDTH  RAM read data (combinational w.r.t. mem_addr)
//  busy        out  1           frame active or write pending; CPU must not access RAM while high
//  frame_done  out  1           1-cycle pulse when cs_n rises after a valid command frame
//  cmd_err     out  1           1-cycle pulse when an unknown command byte completes
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters, shift registers and mem_addr cleared. Reset mid-frame aborts with no RAM write.
//  Synchronisation: sclk, cs_n and mosi each pass a 2-FF synchroniser.
//   Rising/falling sclk edges are detected on the synchronised sclk; mosi is sampled on the detected rise.
//  States: IDLE -> CMD (on cs_n fall) -> ADDR (8 cmd bits received, code valid).
//   From ADDR -> WDATA or RDATA after ADDR_WIDTH address bits.
//   CMD -> IGNORE on an unknown code; cmd_err pulses on the cycle after the 8th rise.
//   Any state -> IDLE on synchronised cs_n high. A partial word is discarded: no mem write, addr unchanged.
//  WDATA: after the DATA_WIDTH-th rise, the next clk cycle drives mem_en=1, mem_we=1, mem_wdata=word, mem_addr=current.
//   The cycle after that, mem_addr increments. Bit counter restarts for the next word.
//  RDATA: on each detected sclk fall with bit_cnt==0, pulse mem_en=1 (mem_we=0) and load tx_shift<=mem_rdata.
//   On other falls, shift tx_shift left by 1.
//   The first load occurs on the fall that follows the last address bit.
//   mem_addr increments in the cycle after the DATA_WIDTH-th rise of each word.
//  spi_miso = tx_shift[DATA_WIDTH-1] in RDATA; 0 in all other states.
//  Address wrap: mem_addr increments from 2^ADDR_WIDTH-1 to 0, with no error.
//  busy = (state != IDLE) or a write strobe is pending. It deasserts the cycle after return to IDLE.
//  frame_done pulses once on return to IDLE from ADDR/WDATA/RDATA. It does not pulse from IGNORE or after a CMD abort.
//  cs_n rise in the same cycle as a write-word completion: the write is performed, then IDLE.
//  Only one RAM strobe per word; mem_en is never high for more than 1 consecutive cycle.
// TESTING
//  1 Write 02,05,DEADBEEF -> single mem_en&mem_we pulse, addr 0x05, wdata 0xDEADBEEF; frame_done pulses after cs_n rise.
//  2 Burst write 02,FE,11111111,22222222,33333333 -> writes land at 0xFE, 0xFF, 0x00 (wrap); exactly 3 strobes.
//  3 Preload RAM[0x10]=0x00010212, [0x11]=0x10020312; read 03,10 then 64 clocks -> MISO returns both words MSB first; 2 read strobes, no we.
//  4 Command 0x5A then 40 clocks -> cmd_err pulses once; no mem_en; MISO stays 0; no frame_done.
//  5 Write 02,20 then 17 data bits, then cs_n high -> no strobe; busy falls; next write 02,20,CAFEF00D lands at 0x20.
//  6 Assert rst mid-burst (during WDATA bit 12) -> all outputs 0 next cycle; no write; a clean frame afterwards works.

Source files
------------

// File: rtl/spi_ram_loader.sv
// SPI mode-0 slave that bursts words into / out of a single-port RAM (cmd, address, data words).
// All SPI inputs are resynchronised to clk; clk must run at least 8x sclk.
module spi_ram_loader #(
  parameter int         ADDR_WIDTH = 8,
  parameter int         DATA_WIDTH = 32,
  parameter logic [7:0] CMD_WRITE  = 8'h02,
  parameter logic [7:0] CMD_READ   = 8'h03
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  cmd_err
);
  localparam int CW = $clog2(DATA_WIDTH + ADDR_WIDTH + 8);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, IGNORE} state_t;
  state_t state, state_n;

  logic [1:0]            sclk_sync, cs_sync, mosi_sync;
  logic                  sclk_q, sclk_s, cs_s, mosi_s, rise, fall;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-2:0] rx_shift;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [7:0]            cmd_byte;
  logic                  wr_mode;
  logic                  cnt_clr, cmd_done, addr_load, wr_word, rd_load, rd_shift, rd_inc;
  logic                  done_set, err_set;

  assign sclk_s   = sclk_sync[1];
  assign cs_s     = cs_sync[1];
  assign mosi_s   = mosi_sync[1];
  assign rise     = sclk_s & ~sclk_q;
  assign fall     = ~sclk_s & sclk_q;
  assign cmd_byte = {rx_shift[6:0], mosi_s};
  assign spi_miso = (state == RDATA) ? tx_shift[DATA_WIDTH-1] : 1'b0;

  // cs_n synchroniser resets to the idle (deasserted) level so reset never opens a frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sclk_q    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_sclk};
      cs_sync   <= {cs_sync[0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sclk_q    <= sclk_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    cnt_clr   = 1'b0;
    cmd_done  = 1'b0;
    addr_load = 1'b0;
    wr_word   = 1'b0;
    rd_load   = 1'b0;
    rd_shift  = 1'b0;
    rd_inc    = 1'b0;
    done_set  = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (!cs_s) begin
          state_n = CMD;
          cnt_clr = 1'b1;
        end
      end
      CMD: begin
        if (cs_s) begin
          state_n = IDLE;
        end else if (rise && bit_cnt == CW'(7)) begin
          cnt_clr  = 1'b1;
          cmd_done = 1'b1;
          if (cmd_byte == CMD_WRITE || cmd_byte == CMD_READ) begin
            state_n = ADDR;
          end else begin
            state_n = IGNORE;
            err_set = 1'b1;
          end
        end
      end
      ADDR: begin
        if (cs_s) begin
          state_n  = IDLE;
          done_set = 1'b1;
        end else if (rise && bit_cnt == CW'(ADDR_WIDTH-1)) begin
          addr_load = 1'b1;
          cnt_clr   = 1'b1;
          state_n   = wr_mode ? WDATA : RDATA;
        end
      end
      WDATA: begin
        // a word finishing together with cs_n rising is still written
        if (rise && bit_cnt == CW'(DATA_WIDTH-1)) begin
          wr_word = 1'b1;
          cnt_clr = 1'b1;
        end
        if (cs_s) begin
          state_n  = IDLE;
          done_set = 1'b1;
        end
      end
      RDATA: begin
        if (cs_s) begin
          state_n  = IDLE;
          done_set = 1'b1;
        end else begin
          if (fall && bit_cnt == '0) rd_load  = 1'b1;
          else if (fall)             rd_shift = 1'b1;
          if (rise && bit_cnt == CW'(DATA_WIDTH-1)) begin
            rd_inc  = 1'b1;
            cnt_clr = 1'b1;
          end
        end
      end
      IGNORE: begin
        if (cs_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      wr_mode    <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      if (cnt_clr)   bit_cnt <= '0;
      else if (rise) bit_cnt <= bit_cnt + CW'(1);
      if (rise)      rx_shift <= {rx_shift[DATA_WIDTH-3:0], mosi_s};
      if (cmd_done)  wr_mode <= (cmd_byte == CMD_WRITE);
      if (rd_load)       tx_shift <= mem_rdata;
      else if (rd_shift) tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
      mem_en <= wr_word | rd_load;
      mem_we <= wr_word;
      if (wr_word) mem_wdata <= {rx_shift, mosi_s};
      // write strobes advance the address after the strobe cycle, reads on the word's last rise
      if (addr_load)                      mem_addr <= {rx_shift[ADDR_WIDTH-2:0], mosi_s};
      else if ((mem_en && mem_we) || rd_inc) mem_addr <= mem_addr + ADDR_WIDTH'(1);
      busy       <= (state != IDLE) || wr_word || (mem_en && mem_we);
      frame_done <= done_set;
      cmd_err    <= err_set;
    end
  end
endmodule

// File: tb/tb_spi_ram_loader.sv
// Bench for spi_ram_loader: SPI host tasks queue expected RAM strobes and read words; a monitor checks them.
module tb_spi_ram_loader;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic        spi_miso, mem_en, mem_we, busy, frame_done, cmd_err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] ram [256] = '{default: 32'h0};
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = 8'h0;
  logic [31:0] pl_data = 32'h0;

  typedef struct {logic we; logic [7:0] addr; logic [31:0] data;} exp_t;
  exp_t        expq[$];
  logic [31:0] rdq[$];
  logic [31:0] rd_word = 32'h0;
  logic        rd_tog = 1'b0, rd_seen = 1'b0;

  int tests = 0, fails = 0;
  int strobes = 0, dones = 0, errs = 0;
  logic prev_en = 1'b0;

  always #5 clk = ~clk;

  spi_ram_loader dut (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .frame_done(frame_done),
    .cmd_err(cmd_err)
  );

  assign mem_rdata = ram[mem_addr];

  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (pl_en)            ram[pl_addr]  <= pl_data;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      prev_en <= 1'b0;
    end else begin
      prev_en <= mem_en;
      if (mem_en) begin
        strobes++;
        chk("strobe_single_cycle", {31'b0, prev_en}, 32'h0);
        if (expq.size() == 0) begin
          chk("strobe_unexpected", 32'h1, 32'h0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("strobe_we", {31'b0, mem_we}, {31'b0, e.we});
          chk("strobe_addr", {24'b0, mem_addr}, {24'b0, e.addr});
          if (e.we) chk("strobe_wdata", mem_wdata, e.data);
        end
      end
      if (frame_done) dones++;
      if (cmd_err)    errs++;
      if (rd_tog != rd_seen) begin
        rd_seen <= rd_tog;
        if (rdq.size() == 0) chk("miso_unexpected", 32'h1, 32'h0);
        else                 chk("miso_word", rd_word, rdq.pop_front());
      end
    end
  end

  task automatic spi_bit(input logic b, output logic so);
    spi_sclk = 1'b0;
    spi_mosi = b;
    repeat (HALF) @(negedge clk);
    so = spi_miso;
    spi_sclk = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic xfer(input logic [31:0] val, input int nbits, output logic [31:0] rd);
    logic so;
    rd = 32'h0;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_bit(val[i], so);
      rd = {rd[30:0], so};
    end
  endtask

  task automatic send(input logic [31:0] val, input int nbits);
    logic [31:0] dummy;
    xfer(val, nbits, dummy);
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    spi_sclk = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    e.we = 1'b1; e.addr = a; e.data = d;
    expq.push_back(e);
  endtask

  task automatic push_rd(input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    e.we = 1'b0; e.addr = a; e.data = d;
    expq.push_back(e);
    rdq.push_back(d);
  endtask

  task automatic write_frame(input logic [7:0] a, input logic [31:0] d);
    push_wr(a, d);
    cs_low();
    send(32'h02, 8);
    send({24'b0, a}, 8);
    send(d, 32);
    cs_high();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int s0, d0, e0, n;
    logic [31:0] w;

    repeat (3) @(negedge clk);
    chk("reset_ctrl", {26'b0, spi_miso, mem_en, mem_we, busy, frame_done, cmd_err}, 32'h0);
    chk("reset_addr", {24'b0, mem_addr}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_after_reset", {26'b0, spi_miso, mem_en, mem_we, busy, frame_done, cmd_err}, 32'h0);

    // 1: single write
    s0 = strobes; d0 = dones;
    write_frame(8'h05, 32'hDEADBEEF);
    chk("t1_strobes", strobes - s0, 1);
    chk("t1_frame_done", dones - d0, 1);
    chk("t1_ram", ram[5], 32'hDEADBEEF);

    // 2: burst write wrapping past 0xFF
    s0 = strobes; d0 = dones;
    push_wr(8'hFE, 32'h11111111);
    push_wr(8'hFF, 32'h22222222);
    push_wr(8'h00, 32'h33333333);
    cs_low();
    send(32'h02, 8); send(32'hFE, 8);
    send(32'h11111111, 32); send(32'h22222222, 32); send(32'h33333333, 32);
    cs_high();
    chk("t2_strobes", strobes - s0, 3);
    chk("t2_ram_fe", ram[8'hFE], 32'h11111111);
    chk("t2_ram_ff", ram[8'hFF], 32'h22222222);
    chk("t2_ram_00", ram[8'h00], 32'h33333333);

    // 3: burst read of two preloaded words
    pl_en = 1'b1; pl_addr = 8'h10; pl_data = 32'h00010212;
    @(negedge clk);
    pl_addr = 8'h11; pl_data = 32'h10020312;
    @(negedge clk);
    pl_en = 1'b0;
    s0 = strobes; d0 = dones;
    push_rd(8'h10, 32'h00010212);
    push_rd(8'h11, 32'h10020312);
    cs_low();
    send(32'h03, 8); send(32'h10, 8);
    for (int k = 0; k < 2; k++) begin
      xfer(32'h0, 32, w);
      rd_word = w;
      rd_tog  = ~rd_tog;
      repeat (2) @(negedge clk);
    end
    cs_high();
    chk("t3_strobes", strobes - s0, 2);
    chk("t3_frame_done", dones - d0, 1);

    // 4: unknown command is ignored
    s0 = strobes; d0 = dones; e0 = errs;
    cs_low();
    send(32'h5A, 8);
    xfer(32'hFFFFFFFF, 32, w);
    chk("t4_miso_zero", w, 32'h0);
    send(32'hFF, 8);
    cs_high();
    chk("t4_cmd_err", errs - e0, 1);
    chk("t4_no_strobe", strobes - s0, 0);
    chk("t4_no_frame_done", dones - d0, 0);

    // 5: partial word discarded, then a clean write to the same address
    s0 = strobes;
    cs_low();
    send(32'h02, 8); send(32'h20, 8); send(32'h1ABCD, 17);
    cs_high();
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t5_busy_low", {31'b0, busy}, 32'h0);
    chk("t5_no_strobe", strobes - s0, 0);
    write_frame(8'h20, 32'hCAFEF00D);
    chk("t5_ram", ram[8'h20], 32'hCAFEF00D);

    // 6: reset in the middle of a write word
    s0 = strobes;
    cs_low();
    send(32'h02, 8); send(32'h30, 8); send(32'h0ABC, 12);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_reset_ctrl", {26'b0, spi_miso, mem_en, mem_we, busy, frame_done, cmd_err}, 32'h0);
    chk("t6_reset_addr", {24'b0, mem_addr}, 32'h0);
    chk("t6_reset_wdata", mem_wdata, 32'h0);
    spi_cs_n = 1'b1; spi_sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_no_strobe", strobes - s0, 0);
    chk("t6_ram_untouched", ram[8'h30], 32'h0);
    write_frame(8'h31, 32'h12345678);
    chk("t6_clean_ram", ram[8'h31], 32'h12345678);

    repeat (10) @(negedge clk);
    chk("expq_drained", expq.size(), 0);
    chk("rdq_drained", rdq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
